// File: rtl/instruction_fetch_decode.sv
// Instruction fetch and decode front end.
// A PC register addresses an external combinational instruction ROM. The
// returned 9-bit word is captured in an instruction register (IR), along with
// the address it came from. The decode fields are plain slices of the IR.
// Taken branches redirect the PC relative to the branch address. A halt word
// parks the unit in HALTED until start is pulsed again.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | out of reset; PC at RESET_PC, nothing fetched, waits for start
// RUN     | one fetch per unstalled cycle; branch and halt acted on from IR
// HALTED  | halt word retired; PC parked at halt address+1, waits for start
module instruction_fetch_decode #(
    parameter logic [7:0] RESET_PC = 8'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stall,
    input  logic       branch_taken,
    input  logic [7:0] branch_offset,
    input  logic [8:0] instruction,
    output logic [7:0] address,
    output logic       ir_valid,
    output logic [7:0] ir_pc,
    output logic [3:0] opcode,
    output logic [1:0] rs,
    output logic [2:0] rt,
    output logic       sel,
    output logic [3:0] imm,
    output logic       halted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [3:0] OP_BRANCH   = 4'b1100;
    localparam logic [3:0] OP_HALT     = 4'b0111;
    localparam logic [2:0] HALT_RT_TAG = 3'b010;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] pc_q;
    logic [7:0] pc_d;
    logic [8:0] ir_q;
    logic [8:0] ir_d;
    logic [7:0] ir_pc_q;
    logic [7:0] ir_pc_d;
    logic       ir_valid_q;
    logic       ir_valid_d;
    logic       halted_q;

    logic       is_halt;
    logic       is_branch;
    logic [7:0] branch_target;

    // Halt ignores the rs field; branch only counts when the IR is live.
    always_comb begin
        is_halt       = ir_valid_q && (ir_q[8:5] == OP_HALT) && (ir_q[2:0] == HALT_RT_TAG);
        is_branch     = ir_valid_q && (ir_q[8:5] == OP_BRANCH) && branch_taken;
        branch_target = ir_pc_q + branch_offset;
    end

    // Next-state and datapath update: stall beats halt beats branch beats fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;

        unique case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d    = RUN;
                    pc_d       = RESET_PC;
                    ir_valid_d = 1'b0;
                end
            end

            RUN: begin
                if (!stall) begin
                    if (is_halt) begin
                        // PC already points past the halt word; leave it there.
                        state_d    = HALTED;
                        ir_valid_d = 1'b0;
                    end else if (is_branch) begin
                        // The word fetched this cycle is on the wrong path.
                        pc_d       = branch_target;
                        ir_valid_d = 1'b0;
                    end else begin
                        ir_d       = instruction;
                        ir_pc_d    = pc_q;
                        ir_valid_d = 1'b1;
                        pc_d       = pc_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                pc_d       = RESET_PC;
                ir_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 9'b0;
            ir_pc_q    <= 8'd0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= (state_d == HALTED);
        end
    end

    // Outputs come straight from registers; decode fields are IR slices.
    always_comb begin
        address  = pc_q;
        ir_valid = ir_valid_q;
        ir_pc    = ir_pc_q;
        halted   = halted_q;
        opcode   = ir_q[8:5];
        rs       = ir_q[4:3];
        rt       = ir_q[2:0];
        sel      = ir_q[4];
        imm      = ir_q[3:0];
    end

endmodule

// File: tb/tb_instruction_fetch_decode.sv
// Directed bench for instruction_fetch_decode with a combinational ROM model.
module tb_instruction_fetch_decode;

    logic       clock;
    logic       reset;
    logic       start;
    logic       stall;
    logic       branch_taken;
    logic [7:0] branch_offset;
    logic [8:0] instruction;
    logic [7:0] address;
    logic       ir_valid;
    logic [7:0] ir_pc;
    logic [3:0] opcode;
    logic [1:0] rs;
    logic [2:0] rt;
    logic       sel;
    logic [3:0] imm;
    logic       halted;

    logic [8:0] rom [256];

    int vectors;
    int miscompares;

    instruction_fetch_decode #(.RESET_PC(8'd0)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_offset(branch_offset),
        .instruction(instruction),
        .address(address),
        .ir_valid(ir_valid),
        .ir_pc(ir_pc),
        .opcode(opcode),
        .rs(rs),
        .rt(rt),
        .sel(sel),
        .imm(imm),
        .halted(halted)
    );

    assign instruction = rom[address];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_irpc(input logic [7:0] target);
        int n;
        n = 0;
        while (!(ir_valid === 1'b1 && ir_pc === target) && n < 600) begin
            tick();
            n++;
        end
        check($sformatf("reach_irpc_%0d", target), 32'(n < 600), 32'd1);
    endtask

    task automatic wait_addr(input logic [7:0] target);
        int n;
        n = 0;
        while (address !== target && n < 600) begin
            tick();
            n++;
        end
        check($sformatf("reach_addr_%0d", target), 32'(n < 600), 32'd1);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        start         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 8'h00;
        for (int i = 0; i < 256; i++) rom[i] = 9'h000;
        rom[0]   = 9'b1010_0_0001;
        rom[11]  = 9'b1100_00_000;
        rom[19]  = 9'b0101_10_011;
        rom[36]  = 9'b1100_01_101;
        rom[42]  = 9'b0111_00_010;
        rom[250] = 9'b1100_11_111;

        // Reset state
        tick();
        check("rst_addr", 32'(address), 32'd0);
        check("rst_valid", 32'(ir_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_irpc", 32'(ir_pc), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);

        // Idle holds without start
        reset = 1'b0;
        tick();
        check("idle_hold_addr", 32'(address), 32'd0);
        check("idle_hold_valid", 32'(ir_valid), 32'd0);

        // Start and first fetches
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_addr", 32'(address), 32'd0);
        check("start_valid", 32'(ir_valid), 32'd0);
        tick();
        check("f0_addr", 32'(address), 32'd1);
        check("f0_valid", 32'(ir_valid), 32'd1);
        check("f0_irpc", 32'(ir_pc), 32'd0);
        check("f0_opcode", 32'(opcode), 32'hA);
        check("f0_sel", 32'(sel), 32'd0);
        check("f0_imm", 32'(imm), 32'h1);
        check("f0_rs", 32'(rs), 32'd0);
        check("f0_rt", 32'(rt), 32'd1);
        tick();
        check("f1_addr", 32'(address), 32'd2);

        // start while running is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_start_ign", 32'(address), 32'd3);
        check("run_start_irpc", 32'(ir_pc), 32'd2);

        // Forward branch 11 + 0x0F = 26, fetched word at 12 squashed
        wait_irpc(8'd11);
        check("br1_pre_addr", 32'(address), 32'd12);
        branch_taken  = 1'b1;
        branch_offset = 8'h0F;
        tick();
        check("br1_addr", 32'(address), 32'd26);
        check("br1_valid", 32'(ir_valid), 32'd0);
        tick();
        // IR is invalid here, so branch_taken must be ignored
        check("br1_ign_inv_addr", 32'(address), 32'd27);
        check("br1_resume_irpc", 32'(ir_pc), 32'd26);
        check("br1_resume_valid", 32'(ir_valid), 32'd1);
        tick();
        // IR holds a non-branch opcode, so branch_taken is ignored again
        check("br_ign_op_addr", 32'(address), 32'd28);
        branch_taken = 1'b0;

        // Backward branch 36 + 0xE3 = 7, with stall taking priority first
        wait_irpc(8'd36);
        branch_taken  = 1'b1;
        branch_offset = 8'hE3;
        stall         = 1'b1;
        tick();
        check("br2_stall_addr", 32'(address), 32'd37);
        check("br2_stall_valid", 32'(ir_valid), 32'd1);
        stall = 1'b0;
        tick();
        branch_taken = 1'b0;
        check("br2_addr", 32'(address), 32'd7);
        check("br2_valid", 32'(ir_valid), 32'd0);

        // Stall three cycles at address 20
        wait_addr(8'd20);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr", 32'(address), 32'd20);
            check("stall_irpc", 32'(ir_pc), 32'd19);
            check("stall_valid", 32'(ir_valid), 32'd1);
            check("stall_opcode", 32'(opcode), 32'h5);
            check("stall_rt", 32'(rt), 32'd3);
        end
        stall = 1'b0;
        tick();
        check("unstall_irpc", 32'(ir_pc), 32'd20);
        check("unstall_addr", 32'(address), 32'd21);

        // Halt at 42
        wait_irpc(8'd42);
        check("halt_pre_addr", 32'(address), 32'd43);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_flag", 32'(halted), 32'd1);
            check("halt_addr", 32'(address), 32'd43);
            check("halt_valid", 32'(ir_valid), 32'd0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_halted", 32'(halted), 32'd0);
        check("restart_addr", 32'(address), 32'd0);
        check("restart_valid", 32'(ir_valid), 32'd0);
        rom[42] = 9'h000;

        // Wrapping branch 250 + 0x10 = 10
        wait_irpc(8'd250);
        branch_taken  = 1'b1;
        branch_offset = 8'h10;
        tick();
        branch_taken = 1'b0;
        check("br3_wrap_addr", 32'(address), 32'd10);
        check("br3_valid", 32'(ir_valid), 32'd0);

        // Sequential fetch wraps 255 -> 0
        wait_addr(8'd255);
        tick();
        check("pc_wrap_addr", 32'(address), 32'd0);
        check("pc_wrap_irpc", 32'(ir_pc), 32'd255);

        // Reset together with a taken branch
        wait_irpc(8'd11);
        branch_taken  = 1'b1;
        branch_offset = 8'h0F;
        reset         = 1'b1;
        tick();
        check("rst_br_addr", 32'(address), 32'd0);
        check("rst_br_valid", 32'(ir_valid), 32'd0);
        check("rst_br_irpc", 32'(ir_pc), 32'd0);
        check("rst_br_opcode", 32'(opcode), 32'd0);
        check("rst_br_halted", 32'(halted), 32'd0);
        reset        = 1'b0;
        branch_taken = 1'b0;
        tick();
        tick();
        check("rst_idle_addr", 32'(address), 32'd0);
        check("rst_idle_valid", 32'(ir_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_decode.md
INSTRUCTION_FETCH_DECODE -- requirements
Module: instruction_fetch_decode

Interface
REQ-001 SHALL have parameter: RESET_PC, 8'd0, program start address loaded on reset and on start.
REQ-002 SHALL have port: clock  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  reset is synchronous and active-high.
REQ-004 SHALL have port: start  input  1  begin/restart execution at RESET_PC from IDLE or HALTED.
REQ-005 SHALL have port: stall  input  1  freeze fetch and decode state this cycle.
REQ-006 SHALL have port: branch_taken  input  1  execute stage reports the decoded branch (opcode 1100) is taken.
REQ-007 SHALL have port: branch_offset  input  8  two's-complement offset, relative to branch instruction address.
REQ-008 SHALL have port: instruction  input  9  word returned combinationally by instruction ROM for address.
REQ-009 SHALL have port: address  output  8  instruction ROM address, equal to PC register.
REQ-010 SHALL have port: ir_valid  output  1  instruction register holds a live instruction.
REQ-011 SHALL have port: ir_pc  output  8  address from which instruction register was fetched.
REQ-012 SHALL have ports: opcode output 4 = IR[8:5]; rs output 2 = IR[4:3]; rt output 3 = IR[2:0]; sel output 1 = IR[4]; imm output 4 = IR[3:0].
REQ-013 SHALL have port: halted  output  1  high while in HALTED state.

Function
REQ-014 SHALL implement states IDLE, RUN, HALTED; address SHALL be driven from the PC register only (no combinational path from inputs).
REQ-015 IDLE/HALTED: start=1 -> next state RUN, PC <= RESET_PC, ir_valid <= 0; otherwise all registers hold.
REQ-016 RUN, stall=0, no redirect: IR <= instruction, ir_pc <= PC, ir_valid <= 1, PC <= PC+1 mod 256 (255 wraps to 0).
REQ-017 Decode fields SHALL be pure combinational slices of IR; they SHALL be treated as meaningful only when ir_valid=1.
REQ-018 Branch: in RUN, stall=0, ir_valid=1, opcode=1100 and branch_taken=1 -> PC <= ir_pc + branch_offset (8-bit, wrap mod 256), ir_valid <= 0 (word fetched this cycle squashed).
REQ-019 branch_taken SHALL be ignored when ir_valid=0 or opcode!=1100.
REQ-020 Halt: in RUN, stall=0, ir_valid=1, IR=9'b0111_xx_010 -> state HALTED, ir_valid <= 0, PC holds (halt address+1), word fetched this cycle discarded.
REQ-021 Halt detection SHALL take priority over fetch; branch and halt are mutually exclusive by opcode.
REQ-022 stall=1 SHALL hold PC, IR, ir_pc, ir_valid and state, and SHALL take priority over fetch, branch and halt; branch_taken must be re-presented when stall drops.
REQ-023 start=1 while in RUN SHALL be ignored.
REQ-024 halted SHALL be registered state, high exactly while state=HALTED.

Reset
REQ-025 reset=1 at a rising edge SHALL override all other inputs: state IDLE, PC=RESET_PC, IR=9'b0, ir_pc=0, ir_valid=0, halted=0.
REQ-026 Reset mid-operation (RUN, pending branch, HALTED) SHALL yield the same values as REQ-025 on the next edge.

Verification
REQ-027 Reset, start pulse, ROM model: address 0,1,2 on successive cycles; ir_valid=1 with ir_pc=0, opcode=1010, sel=0, imm=0001 one cycle after address=0.
REQ-028 Branch at ir_pc=11, branch_offset=8'h0F, branch_taken=1 -> next address=26; ir_valid=0 for one cycle (word at 12 squashed).
REQ-029 Backward branch at ir_pc=36, branch_offset=8'hE3 -> next address=7; wrap check: ir_pc=250, offset 8'h10 -> address=10.
REQ-030 Halt word 9'b0111_00_010 at address 42 -> halted=1, address holds 43, ir_valid=0 indefinitely; start -> halted=0, address=0.
REQ-031 stall=1 for 3 cycles at address=20 -> address, IR, ir_pc, ir_valid unchanged; fetch resumes at 20 when stall drops; sequential fetch from 255 -> next address=0.
REQ-032 reset asserted same cycle as branch_taken=1 -> all outputs at REQ-025 values next cycle; state IDLE until start.
